// File: rtl/irq_ctrl.sv
// 8-source fixed-priority interrupt controller on the core I/O bus.
// It synchronises and latches requests and sequences one interrupt at a time: assert, EOI, low gap.
module irq_ctrl #(
    parameter logic [7:0]  BASE_ADDR   = 8'hF0,
    parameter int unsigned N_SRC       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] src_i,
    input  logic [7:0] io_addr_i,
    input  logic [7:0] io_data_i,
    input  logic       io_we_i,
    output logic [7:0] io_data_o,
    output logic       irq_o
);

    localparam logic [7:0] SRC_EN = 8'((16'd1 << N_SRC) - 16'd1);
    localparam logic [7:0] A_PEND = BASE_ADDR;
    localparam logic [7:0] A_MASK = BASE_ADDR + 8'd1;
    localparam logic [7:0] A_MODE = BASE_ADDR + 8'd2;
    localparam logic [7:0] A_VEC  = BASE_ADDR + 8'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        WAIT_EOI = 2'd2,
        GAP      = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0] s, s_prev_q, pend_q, mask_q, mode_q;
    logic [7:0] rise, wr_clr, eoi_clr, pend_d, req;
    logic [2:0] vec_q, winner;
    logic       wr_pend, wr_mask, wr_mode, eoi, in_service;
    state_t     state_q;
    logic       irq_q;

    assign s          = sync_q[SYNC_STAGES-1];
    assign wr_pend    = io_we_i && (io_addr_i == A_PEND);
    assign wr_mask    = io_we_i && (io_addr_i == A_MASK);
    assign wr_mode    = io_we_i && (io_addr_i == A_MODE);
    assign eoi        = io_we_i && (io_addr_i == A_VEC);
    assign in_service = (state_q == ASSERT) || (state_q == WAIT_EOI);

    // Edge bits: set beats clear; level bits simply track the synchronised line.
    always_comb begin
        rise    = s & ~s_prev_q;
        wr_clr  = wr_pend ? (io_data_i & ~mode_q) : 8'h00;
        eoi_clr = (in_service && eoi) ? (8'(8'd1 << vec_q) & ~mode_q) : 8'h00;
        pend_d  = ((((pend_q & ~(wr_clr | eoi_clr)) | rise) & ~mode_q) | (s & mode_q)) & SRC_EN;
        req     = pend_q & mask_q & SRC_EN;
    end

    // Lowest index wins.
    always_comb begin
        winner = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) winner = 3'(i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            s_prev_q <= 8'h00;
            pend_q   <= 8'h00;
            mask_q   <= 8'h00;
            mode_q   <= 8'h00;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], src_i};
            s_prev_q <= s;
            pend_q   <= pend_d;
            if (wr_mask) mask_q <= io_data_i & SRC_EN;
            if (wr_mode) mode_q <= io_data_i & SRC_EN;
        end
    end

    // Request sequencer; GAP guarantees a low cycle so the core edge detector re-arms.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
            vec_q   <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req != 8'h00) begin
                        vec_q   <= winner;
                        irq_q   <= 1'b1;
                        state_q <= ASSERT;
                    end
                end
                ASSERT, WAIT_EOI: begin
                    if (eoi) begin
                        irq_q   <= 1'b0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    irq_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    irq_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        io_data_o = 8'h00;
        case (io_addr_i)
            A_PEND:  io_data_o = pend_q;
            A_MASK:  io_data_o = mask_q;
            A_MODE:  io_data_o = mode_q;
            A_VEC:   io_data_o = {in_service, 4'b0000, vec_q};
            default: io_data_o = 8'h00;
        endcase
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expectations queued alongside stimulus, drained against DUT outputs.
module tb_irq_ctrl;

    localparam logic [7:0] A_PEND = 8'hF0;
    localparam logic [7:0] A_MASK = 8'hF1;
    localparam logic [7:0] A_MODE = 8'hF2;
    localparam logic [7:0] A_VEC  = 8'hF3;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [7:0] src_i = 8'h00;
    logic [7:0] io_addr_i = 8'h00;
    logic [7:0] io_data_i = 8'h00;
    logic       io_we_i = 1'b0;
    logic [7:0] io_data_o;
    logic       irq_o;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic       is_irq;
        logic [7:0] addr;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];

    irq_ctrl #(.BASE_ADDR(8'hF0), .N_SRC(8), .SYNC_STAGES(2)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .src_i     (src_i),
        .io_addr_i (io_addr_i),
        .io_data_i (io_data_i),
        .io_we_i   (io_we_i),
        .io_data_o (io_data_o),
        .irq_o     (irq_o)
    );

    always #10 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        io_addr_i = a;
        io_data_i = d;
        io_we_i   = 1'b1;
        tick();
        io_we_i   = 1'b0;
    endtask

    task automatic exp_reg(input string tag, input logic [7:0] a, input logic [7:0] e);
        exp_t x;
        x.tag = tag; x.is_irq = 1'b0; x.addr = a; x.exp = e;
        sb.push_back(x);
    endtask

    task automatic exp_irq(input string tag, input logic e);
        exp_t x;
        x.tag = tag; x.is_irq = 1'b1; x.addr = 8'h00; x.exp = {7'd0, e};
        sb.push_back(x);
    endtask

    // Compare every queued expectation against the DUT in the current cycle.
    task automatic drain();
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            if (x.is_irq) begin
                check(x.tag, {7'd0, irq_o}, x.exp);
            end else begin
                io_addr_i = x.addr;
                #1;
                check(x.tag, io_data_o, x.exp);
            end
        end
    endtask

    task automatic pulse(input logic [7:0] bits);
        src_i = bits;
        tick();
        src_i = 8'h00;
    endtask

    initial begin
        // 1: reset state and single edge source latency
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        exp_reg("rst_pend", A_PEND, 8'h00);
        exp_reg("rst_mask", A_MASK, 8'h00);
        exp_reg("rst_mode", A_MODE, 8'h00);
        exp_reg("rst_vec",  A_VEC,  8'h00);
        exp_irq("rst_irq", 1'b0);
        drain();
        wr(A_MASK, 8'hFF);
        pulse(8'h08);
        tick();
        exp_reg("t1_pend_k1", A_PEND, 8'h00);
        drain();
        tick();
        exp_reg("t1_pend_k2", A_PEND, 8'h08);
        exp_irq("t1_irq_k2", 1'b0);
        drain();
        tick();
        exp_irq("t1_irq_k3", 1'b1);
        exp_reg("t1_vec", A_VEC, 8'h83);
        drain();
        wr(A_VEC, 8'h00);
        exp_reg("t1_pend_eoi", A_PEND, 8'h00);
        exp_irq("t1_irq_eoi", 1'b0);
        drain();
        tick();

        // 2: simultaneous sources 5 and 1, priority and gap
        pulse(8'h22);
        tick(); tick(); tick();
        exp_irq("t2_irq", 1'b1);
        exp_reg("t2_vec1", A_VEC, 8'h81);
        exp_reg("t2_pend", A_PEND, 8'h22);
        drain();
        wr(A_VEC, 8'h00);
        exp_irq("t2_gap", 1'b0);
        exp_reg("t2_pend_eoi", A_PEND, 8'h20);
        drain();
        tick();
        exp_irq("t2_idle", 1'b0);
        drain();
        tick();
        exp_irq("t2_irq2", 1'b1);
        exp_reg("t2_vec5", A_VEC, 8'h85);
        drain();
        wr(A_VEC, 8'h00);
        tick(); tick();
        exp_reg("t2_pend_end", A_PEND, 8'h00);
        exp_irq("t2_irq_end", 1'b0);
        exp_reg("t2_vec_idle", A_VEC, 8'h05);
        drain();

        // 3: masked pend, late unmask, W1C, unmapped write
        wr(A_MASK, 8'h00);
        wr(8'hF4, 8'hFF);
        wr(8'hEF, 8'hFF);
        exp_reg("t3_unmapped", A_MASK, 8'h00);
        exp_reg("t3_unmapped_rd", 8'hF4, 8'h00);
        drain();
        pulse(8'h04);
        tick(); tick(); tick();
        exp_reg("t3_pend", A_PEND, 8'h04);
        exp_irq("t3_masked", 1'b0);
        drain();
        wr(A_MASK, 8'h04);
        exp_irq("t3_irq_w", 1'b0);
        drain();
        tick();
        exp_irq("t3_irq", 1'b1);
        exp_reg("t3_vec", A_VEC, 8'h82);
        drain();
        wr(A_PEND, 8'h04);
        exp_reg("t3_w1c", A_PEND, 8'h00);
        exp_irq("t3_irq_hold", 1'b1);
        drain();
        wr(A_VEC, 8'h00);
        tick(); tick();
        exp_reg("t3_pend_end", A_PEND, 8'h00);
        exp_irq("t3_irq_end", 1'b0);
        drain();

        // 4: level source re-asserts after EOI while held
        wr(A_MODE, 8'h01);
        wr(A_MASK, 8'h01);
        src_i = 8'h01;
        tick(); tick(); tick(); tick();
        exp_irq("t4_irq", 1'b1);
        exp_reg("t4_vec", A_VEC, 8'h80);
        drain();
        wr(A_VEC, 8'h00);
        exp_irq("t4_gap", 1'b0);
        exp_reg("t4_pend_held", A_PEND, 8'h01);
        drain();
        tick();
        exp_irq("t4_idle", 1'b0);
        drain();
        tick();
        exp_irq("t4_reassert", 1'b1);
        exp_reg("t4_vec2", A_VEC, 8'h80);
        drain();
        src_i = 8'h00;
        tick(); tick(); tick();
        exp_reg("t4_pend_drop", A_PEND, 8'h00);
        drain();
        wr(A_VEC, 8'h00);
        tick(); tick(); tick();
        exp_irq("t4_irq_end", 1'b0);
        exp_reg("t4_pend_end", A_PEND, 8'h00);
        drain();

        // 5: edge arrival coincides with W1C of the same bit
        wr(A_MODE, 8'h00);
        wr(A_MASK, 8'h00);
        pulse(8'h10);
        tick();
        wr(A_PEND, 8'h10);
        exp_reg("t5_set_wins", A_PEND, 8'h10);
        drain();
        wr(A_PEND, 8'h10);
        exp_reg("t5_cleared", A_PEND, 8'h00);
        drain();

        // 6: reset while asserting
        wr(A_MASK, 8'hFF);
        pulse(8'h40);
        tick(); tick(); tick();
        exp_reg("t6_vec", A_VEC, 8'h86);
        exp_irq("t6_irq", 1'b1);
        drain();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        exp_irq("t6_irq_rst", 1'b0);
        exp_reg("t6_pend", A_PEND, 8'h00);
        exp_reg("t6_mask", A_MASK, 8'h00);
        exp_reg("t6_mode", A_MODE, 8'h00);
        exp_reg("t6_vec_rst", A_VEC, 8'h00);
        drain();
        tick(); tick(); tick();
        exp_irq("t6_irq_quiet", 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- 8-source interrupt controller on the core I/O bus. Drives the core's single `irq_i` line.
- Synchronises and latches external requests, masks them and arbitrates by fixed priority (source 0 highest).
- Exposes status, mask, mode and vector registers through IN/OUT ports.
- Sequences one interrupt at a time: assert, wait for end-of-interrupt (EOI) from software, force a low gap, re-arbitrate.

Parameters:
- BASE_ADDR, 8'hF0, I/O port of register 0; registers occupy BASE_ADDR..BASE_ADDR+3.
- N_SRC, 8, number of active sources (1..8); unused bits read 0 and never pend.
- SYNC_STAGES, 2, flip-flop stages on each src_i bit (>=2).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- src_i  in  8  asynchronous interrupt request lines.
- io_addr_i  in  8  core I/O address.
- io_data_i  in  8  core I/O write data.
- io_we_i  in  1  core I/O write strobe, one cycle.
- io_data_o  out  8  read data; combinational from io_addr_i; 8'h00 when address not decoded.
- irq_o  out  1  registered interrupt request to core `irq_i`.

Behaviour:
Reset:
- rst_i=1 on a clock edge clears sync chains, edge detectors, pend, mask (all masked = 8'h00), mode (all edge = 8'h00) and vec.
- FSM goes to IDLE; irq_o=0.
- Reset mid-ASSERT or mid-WAIT_EOI drops irq_o the next edge and discards the in-service vector.

Registers (offset from BASE_ADDR):
- +0 PEND: read = pend. Write = write-1-to-clear for edge-mode bits; ignored for level-mode bits.
- +1 MASK: read/write; 1 = enabled.
- +2 MODE: read/write; 1 = level, 0 = rising edge.
- +3 VEC: read = {valid, 4'b0, idx[2:0]}, where valid=1 in ASSERT/WAIT_EOI. Write (any data) = EOI.

Source path:
- s = synchronised src_i.
- Edge mode: pend[i] sets when s[i]=1 and s_prev[i]=0.
- Level mode: pend[i] = s[i] every cycle.
- Same-cycle set and clear (PEND write or EOI): set wins.
- Latency: src_i first sampled high at edge k; pend visible after edge k+SYNC_STAGES; irq_o high after edge k+SYNC_STAGES+1 if the FSM is in IDLE.

Arbitration:
- req = pend & mask & N_SRC bit-enable.
- Winner = lowest set index.

FSM:
- IDLE: if req!=0, latch vec=winner, irq_o<=1, go to ASSERT.
- ASSERT: irq_o stays 1 until EOI, then go to GAP.
  - Mask or mode changes here do not alter vec.
  - A higher-priority arrival does not preempt (no nesting).
- On EOI in ASSERT: clear pend[vec] if edge mode, irq_o<=0, go to GAP. A level source re-pends while s is high.
- WAIT_EOI: reserved encoding; unused, treated as ASSERT.
- GAP: irq_o=0 for exactly 1 cycle so the core's rising-edge detector re-arms, then go to IDLE.
- EOI in IDLE or GAP: ignored.
- Minimum irq_o low time between requests: 2 cycles (GAP + IDLE evaluation).
- Writes to unmapped ports have no effect. Reads have no side effects.

Test Plan:
1. Reset, then read +0..+3 -> 00,00,00,00; irq_o=0. Write MASK=FF, pulse src_i[3] for 1 cycle -> PEND=08 at edge k+2, irq_o=1 at k+3, VEC reads 83.
2. Sources 5 and 1 rise in the same cycle, MASK=FF -> VEC=81. EOI -> irq_o=0 for 2 cycles, then irq_o=1 with VEC=85. Second EOI -> PEND=00, irq_o stays 0.
3. MASK=00, pulse src_i[2] -> PEND=04, irq_o=0. Write MASK=04 -> irq_o=1 two cycles later. Write PEND=04 then EOI -> PEND=00.
4. MODE=01, MASK=01, hold src_i[0] high -> irq_o=1. EOI while still high -> after GAP, irq_o reasserts with VEC=80. Drop src_i[0], then EOI -> PEND=00, irq_o stays 0.
5. src_i[4] edge on the same cycle as a PEND write of 10 -> PEND bit 4 remains 1.
6. In ASSERT with VEC=86, assert rst_i one cycle -> irq_o=0 next edge; all registers read 00.
